// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Bundles the request/response handshake and the data-memory bus of the
// memory access controller.
//   req_*   : request from the requester (valid/ready, write, addr, size, wdata)
//   resp_*  : completion pulse, error flag and load data back to the requester
//   mem_*   : address/enables/data/size to the data memory, read data back
// Modports:
//   slave  : controller view (takes requests, drives the memory bus)
//   master : requester/memory view (drives requests, sees responses)
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;

  logic [63:0] mem_address;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Accepts one load/store request at a time, range/size checks it, and issues
// it to a byte-addressed data memory. Aligned requests take one memory cycle
// at full width; misaligned requests are split into single-byte cycles.
// Ports:
//   clk    : single clock, all state on posedge
//   reset  : synchronous active-high reset
//   bus    : mem_access_ctrl_if.slave (request, response and memory bus)
// Parameter:
//   DATA_MEM_SIZE : byte capacity of the attached memory (power of two, > 8)
module mem_access_ctrl #(
  parameter int unsigned DATA_MEM_SIZE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic        write_q;
  logic        aligned_q;
  logic        err_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [3:0]  size_q;
  logic [3:0]  cnt;

  logic        size_ok;
  logic        req_err;
  logic        req_aligned;
  logic [64:0] end_addr;
  logic        accept;
  logic        last_byte;

  function automatic logic [63:0] size_mask(input logic [3:0] size);
    case (size)
      4'd1:    return 64'h0000_0000_0000_00FF;
      4'd2:    return 64'h0000_0000_0000_FFFF;
      4'd4:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Request classification; the end address is formed in 65 bits so an
  // address near 2^64 cannot wrap into the legal range.
  always_comb begin
    size_ok     = (bus.req_size == 4'd1) || (bus.req_size == 4'd2) ||
                  (bus.req_size == 4'd4) || (bus.req_size == 4'd8);
    end_addr    = {1'b0, bus.req_addr} + {61'd0, bus.req_size};
    req_err     = !size_ok || (end_addr > 65'(DATA_MEM_SIZE));
    // Only meaningful for power-of-two sizes, which is all that reaches ACCESS.
    req_aligned = (bus.req_addr[3:0] & (bus.req_size - 4'd1)) == 4'd0;
  end

  // Ready is forced low during reset so nothing is accepted on the reset edge.
  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign last_byte     = aligned_q || (cnt == (size_q - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      aligned_q <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q   <= bus.req_write;
        addr_q    <= bus.req_addr;
        size_q    <= bus.req_size;
        wdata_q   <= bus.req_wdata;
        aligned_q <= req_aligned;
        err_q     <= req_err;
        rdata_q   <= '0;
        cnt       <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
        if (!write_q) begin
          if (aligned_q) begin
            rdata_q <= bus.mem_read_data & size_mask(size_q);
          end else begin
            // Each split cycle returns one byte in lane 0; place it at byte cnt.
            rdata_q[{cnt[2:0], 3'b000} +: 8] <= bus.mem_read_data[7:0];
          end
        end
      end
    end
  end

  // Next state and memory bus drive; the bus idles at zero with size 8.
  always_comb begin
    state_next           = state;
    bus.mem_address      = '0;
    bus.mem_write_enable = 1'b0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_data   = '0;
    bus.mem_xfer_size    = 4'd8;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_write_enable = write_q;
        bus.mem_read_enable  = !write_q;
        if (aligned_q) begin
          bus.mem_address    = addr_q;
          bus.mem_xfer_size  = size_q;
          bus.mem_write_data = wdata_q;
        end else begin
          bus.mem_address    = addr_q + {60'd0, cnt};
          bus.mem_xfer_size  = 4'd1;
          bus.mem_write_data = {56'd0, wdata_q[{cnt[2:0], 3'b000} +: 8]};
        end
        if (last_byte) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. Holds a byte-array data memory
// driven by the DUT and a separate reference byte array updated from the
// load/store rules; directed cases and randomized requests are compared
// against expectations computed from the reference.
module tb_mem_access_ctrl;
  localparam int DEPTH = 1024;

  logic clk;
  logic reset;
  logic mem_init;
  int   checks;
  int   errors;

  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.DATA_MEM_SIZE(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: byte writes commit on posedge; reads are combinational.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (bus.mem_write_enable) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(bus.mem_xfer_size) && (bus.mem_address + 64'(i)) < 64'(DEPTH))
          mem[int'(bus.mem_address + 64'(i))] <= bus.mem_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.mem_read_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(bus.mem_xfer_size) && (bus.mem_address + 64'(i)) < 64'(DEPTH))
        bus.mem_read_data[8*i +: 8] = mem[int'(bus.mem_address + 64'(i))];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic compareMemory(input string tag);
    int diff;
    diff = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diff++;
    checkOutput({tag, " mem_bytes_differing"}, 64'(diff), 64'd0);
  endtask

  // One complete transaction: reference model, drive, cycle-by-cycle bus
  // check, latency/response check, hold check and memory comparison.
  task automatic applyStimulus(input logic write, input logic [63:0] addr, input logic [3:0] size,
                               input logic [63:0] wdata, input string tag);
    logic        exp_err;
    logic        aligned;
    logic [63:0] exp_rdata;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [3:0]  exp_xfer;
    int          exp_lat;
    int          n;
    int          access_cycles;
    int          bad;

    exp_err = !(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8) ||
              (addr > 64'(DEPTH) - 64'(size));
    aligned = !exp_err && ((addr % 64'(size)) == 64'd0);
    exp_lat = exp_err ? 1 : (aligned ? 2 : int'(size) + 1);
    exp_rdata = '0;
    if (!exp_err) begin
      for (int i = 0; i < int'(size); i++) begin
        if (write) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        else exp_rdata = exp_rdata | (64'(ref_mem[int'(addr) + i]) << (8 * i));
      end
    end

    @(negedge clk);
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    #1 checkOutput({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;

    n = 1;
    access_cycles = 0;
    bad = 0;
    while (!bus.resp_valid && n < 20) begin
      exp_addr  = aligned ? addr : addr + 64'(access_cycles);
      exp_xfer  = aligned ? size : 4'd1;
      exp_wdata = aligned ? wdata : ((wdata >> (8 * access_cycles)) & 64'hFF);
      if (bus.mem_write_enable !== write || bus.mem_read_enable !== !write ||
          bus.mem_address !== exp_addr || bus.mem_xfer_size !== exp_xfer ||
          (write && bus.mem_write_data !== exp_wdata) || bus.req_ready !== 1'b0)
        bad++;
      access_cycles++;
      @(negedge clk);
      n++;
    end

    checkOutput({tag, " latency"}, 64'(n), 64'(exp_lat));
    checkOutput({tag, " access_cycles"}, 64'(access_cycles), 64'(exp_lat - 1));
    checkOutput({tag, " access_bus_errors"}, 64'(bad), 64'd0);
    checkOutput({tag, " resp_err"}, 64'(bus.resp_err), 64'(exp_err));
    checkOutput({tag, " resp_rdata"}, bus.resp_rdata, exp_rdata);
    checkOutput({tag, " resp_cycle_bus"},
                64'({bus.mem_write_enable, bus.mem_read_enable, bus.mem_xfer_size}), 64'd8);
    checkOutput({tag, " resp_cycle_addr"}, bus.mem_address, 64'd0);
    @(negedge clk);
    checkOutput({tag, " resp_valid_single"}, 64'(bus.resp_valid), 64'd0);
    checkOutput({tag, " rdata_hold"}, bus.resp_rdata, exp_rdata);
    checkOutput({tag, " err_hold"}, 64'(bus.resp_err), 64'(exp_err));
    compareMemory(tag);
  endtask

  logic [3:0]  size_tab [11];
  logic [63:0] rnd_addr;
  logic [63:0] rnd_data;
  logic [63:0] abort_data;

  initial begin
    checks = 0;
    errors = 0;
    size_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0, 4'd5};
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = 4'd1;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 37 + 11);

    // Reset: memory preload happens on the same edges.
    reset = 1'b1;
    mem_init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("reset resp_err", 64'(bus.resp_err), 64'd0);
    checkOutput("reset resp_rdata", bus.resp_rdata, 64'd0);
    checkOutput("reset mem_bus", 64'({bus.mem_write_enable, bus.mem_read_enable, bus.mem_xfer_size}), 64'd8);
    checkOutput("reset mem_address", bus.mem_address, 64'd0);
    checkOutput("reset mem_write_data", bus.mem_write_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset req_ready", 64'(bus.req_ready), 64'd1);
    compareMemory("preload");

    // Aligned 8-byte store and load back.
    applyStimulus(1'b1, 64'h10, 4'd8, 64'h1122334455667788, "st8_0x10");
    applyStimulus(1'b0, 64'h10, 4'd8, 64'd0, "ld8_0x10");
    checkOutput("ld8_0x10 const", bus.resp_rdata, 64'h1122334455667788);

    // Misaligned 4-byte store split into bytes, then loads.
    applyStimulus(1'b1, 64'h23, 4'd4, 64'h00000000AABBCCDD, "st4_0x23");
    checkOutput("st4_0x23 bytes", 64'({mem[16'h26], mem[16'h25], mem[16'h24], mem[16'h23]}), 64'hAABBCCDD);
    applyStimulus(1'b0, 64'h23, 4'd4, 64'd0, "ld4_0x23");
    checkOutput("ld4_0x23 const", bus.resp_rdata, 64'h00000000AABBCCDD);
    applyStimulus(1'b0, 64'h24, 4'd1, 64'd0, "ld1_0x24");
    checkOutput("ld1_0x24 const", bus.resp_rdata, 64'hCC);

    // Rejected requests: illegal size, range overflow, and wrap-around address.
    applyStimulus(1'b1, 64'h40, 4'd3, 64'hDEADBEEF, "err_size3");
    applyStimulus(1'b0, 64'h3FE, 4'd4, 64'd0, "err_0x3fe");
    checkOutput("err_0x3fe const", 64'(bus.resp_err), 64'd1);
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'd4, 64'h1234, "err_wrap");
    applyStimulus(1'b0, 64'h3F8, 4'd8, 64'd0, "ld8_top");

    // Reset during the third byte of a misaligned 8-byte store.
    abort_data = 64'h0102030405060708 ^ {$urandom, $urandom};
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h101;
    bus.req_size  = 4'd8;
    bus.req_wdata = abort_data;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort third_byte_addr", bus.mem_address, 64'h103);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort ready_in_reset", 64'(bus.req_ready), 64'd0);
    checkOutput("abort enables_in_reset", 64'({bus.mem_write_enable, bus.mem_read_enable}), 64'd0);
    checkOutput("abort resp_valid", 64'(bus.resp_valid), 64'd0);
    reset = 1'b0;
    #1 checkOutput("abort ready_after_reset", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    checkOutput("abort ready_idle", 64'(bus.req_ready), 64'd1);
    checkOutput("abort enables_idle", 64'({bus.mem_write_enable, bus.mem_read_enable}), 64'd0);
    for (int i = 0; i < 3; i++) ref_mem[16'h101 + i] = abort_data[8*i +: 8];
    compareMemory("abort");
    applyStimulus(1'b0, 64'h101, 4'd8, 64'd0, "abort_readback");

    // req_valid held across two back-to-back aligned requests.
    rnd_data = {$urandom, $urandom};
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h40;
    bus.req_size  = 4'd8;
    bus.req_wdata = rnd_data;
    bus.req_valid = 1'b1;
    #1 checkOutput("held A ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    checkOutput("held A access", 64'({bus.req_ready, bus.mem_write_enable, bus.resp_valid}), 64'b010);
    bus.req_write = 1'b0;
    bus.req_wdata = 64'd0;
    @(negedge clk);
    checkOutput("held A resp", 64'({bus.req_ready, bus.mem_read_enable, bus.resp_valid}), 64'b001);
    @(negedge clk);
    checkOutput("held idle", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("held B access", 64'({bus.req_ready, bus.mem_read_enable, bus.resp_valid}), 64'b010);
    @(negedge clk);
    checkOutput("held B resp", 64'({bus.req_ready, bus.resp_valid}), 64'b01);
    checkOutput("held B rdata", bus.resp_rdata, rnd_data);
    @(negedge clk);
    checkOutput("held end", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
    for (int i = 0; i < 8; i++) ref_mem[16'h40 + i] = rnd_data[8*i +: 8];
    compareMemory("held");

    // Randomized requests against the reference byte array.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) rnd_addr = {$urandom, $urandom};
      else if ($urandom_range(0, 3) == 0) rnd_addr = 64'($urandom_range(DEPTH - 12, DEPTH - 1));
      else rnd_addr = 64'($urandom_range(0, DEPTH - 1));
      rnd_data = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), rnd_addr, size_tab[$urandom_range(0, 10)],
                    rnd_data, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: DATA_MEM_SIZE, 1024, byte capacity of the attached data memory; power of two, greater than 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  access request present.
REQ-005 SHALL have port: req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_addr  input  64  byte address; any alignment.
REQ-008 SHALL have port: req_size  input  4  transfer size in bytes: 1, 2, 4 or 8.
REQ-009 SHALL have port: req_wdata  input  64  store data, little-endian; byte i = bits 8i+7..8i.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_err  output  1  request rejected; qualified by resp_valid.
REQ-012 SHALL have port: resp_rdata  output  64  load result, zero-extended above req_size bytes.
REQ-013 SHALL have ports to the data memory: mem_address  output  64; mem_write_enable  output  1; mem_read_enable  output  1; mem_write_data  output  64; mem_xfer_size  output  4; mem_read_data  input  64 (combinational read; write commits on posedge clk).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 SHALL assert req_ready only in IDLE; acceptance = req_valid && req_ready at a posedge; all req_* fields are latched at acceptance.
REQ-016 SHALL classify the request as an error if req_size is not in {1,2,4,8} or req_addr + req_size > DATA_MEM_SIZE, using 65-bit arithmetic so the sum cannot wrap.
REQ-017 SHALL, on error, go IDLE -> RESP directly, with no memory enable asserted, resp_err = 1 and resp_rdata = 0.
REQ-018 SHALL treat the request as aligned when req_addr mod req_size = 0 and perform exactly 1 ACCESS cycle with mem_address = addr, mem_xfer_size = size and mem_write_data = wdata.
REQ-019 SHALL treat the request as misaligned otherwise and perform exactly req_size ACCESS cycles; in cycle i (i = 0..size-1) mem_address = addr+i, mem_xfer_size = 1, mem_write_data[7:0] = wdata byte i and mem_write_data[63:8] = 0.
REQ-020 SHALL use a byte counter that increments once per ACCESS cycle and moves the FSM to RESP after the last byte.
REQ-021 SHALL assert exactly one of mem_write_enable (store) or mem_read_enable (load) during every ACCESS cycle.
REQ-022 SHALL capture read data at the posedge that ends each ACCESS cycle: for aligned, resp_rdata = mem_read_data masked to size bytes; for misaligned, resp_rdata byte i = mem_read_data[7:0] from cycle i.
REQ-023 SHALL, for a store, return resp_rdata = 0 and resp_err = 0.
REQ-024 SHALL assert resp_valid for exactly 1 cycle in RESP, then return to IDLE; resp_rdata and resp_err SHALL hold until the next acceptance.
REQ-025 SHALL drive, outside ACCESS: mem_write_enable = 0, mem_read_enable = 0, mem_address = 0, mem_write_data = 0, mem_xfer_size = 8.
REQ-026 SHALL have fixed latency: resp_valid is high in the cycle after the last ACCESS cycle (aligned: 2nd cycle after acceptance; misaligned: (size+1)th; error: 1st).
REQ-027 SHALL ignore req_valid while not in IDLE; a request held high is accepted in the first IDLE cycle after RESP.

Reset
REQ-028 SHALL, with reset high at a posedge, enter IDLE and clear the byte counter, resp_valid = 0, resp_err = 0, resp_rdata = 0, and all mem_* outputs to the REQ-025 values.
REQ-029 SHALL abort any operation when reset is asserted mid-operation; a write enabled in the cycle containing the reset edge commits, and no later byte is issued.
REQ-030 SHALL hold req_ready = 0 while reset is high and return it to 1 in the first cycle after reset deasserts.

Verification
REQ-031 SHALL cover: aligned store of size 8, data 0x1122334455667788, to 0x10, then load size 8 from 0x10 -> 1 ACCESS cycle each, resp_rdata = 0x1122334455667788, resp_err = 0.
REQ-032 SHALL cover: misaligned store of size 4, data 0xAABBCCDD, to 0x23 -> 4 byte writes to 0x23..0x26 of DD, CC, BB, AA; then load size 4 from 0x23 -> 0x00000000AABBCCDD; load size 1 from 0x24 -> 0xCC.
REQ-033 SHALL cover: requests with size 3, and with addr 0x3FE and size 4 -> resp_valid in the cycle after acceptance, resp_err = 1, no mem enable asserted at any time.
REQ-034 SHALL cover: misaligned store of size 8 to 0x101, reset asserted during the 3rd ACCESS cycle -> bytes 0x101..0x103 written, 0x104..0x108 unchanged, req_ready = 1 in the first cycle after reset deasserts.
REQ-035 SHALL cover: req_valid held high across two requests -> req_ready = 0 through ACCESS and RESP, second request accepted only in IDLE, exactly one resp_valid pulse per request.
